// File: rtl/rv_wb_stage_if.sv
// Writeback stage bus: upstream pipeline signals in, register-file write
// port and hazard-unit forwarding bus out.
interface rv_wb_stage_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
);
  logic            stall_in;
  logic            flush_in;
  logic            valid_in;
  logic            wb_en_in;
  logic [4:0]      wb_reg_in;
  logic [1:0]      src_sel_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] alu_in;
  logic [XLEN-1:0] io_rdata;
  logic [XLEN-1:0] mem_rdata;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;

  logic            valid_out;
  logic            wb_en_out;
  logic [4:0]      wb_reg_out;
  logic [XLEN-1:0] wb_data;
  logic            df_wb_enable;
  logic [4:0]      df_wb_reg;
  logic [XLEN-1:0] df_wb_data;
  logic [CNTW-1:0] retire_count;

  // Pipeline side: drives instructions, observes writeback
  modport master (
    output stall_in, flush_in, valid_in, wb_en_in, wb_reg_in, src_sel_in,
           pc_in, alu_in, io_rdata, mem_rdata, ld_funct3, ld_addr_lo,
    input  valid_out, wb_en_out, wb_reg_out, wb_data,
           df_wb_enable, df_wb_reg, df_wb_data, retire_count
  );

  // Writeback stage side
  modport slave (
    input  stall_in, flush_in, valid_in, wb_en_in, wb_reg_in, src_sel_in,
           pc_in, alu_in, io_rdata, mem_rdata, ld_funct3, ld_addr_lo,
    output valid_out, wb_en_out, wb_reg_out, wb_data,
           df_wb_enable, df_wb_reg, df_wb_data, retire_count
  );
endinterface

// File: rtl/rv_wb_stage.sv
// RV32I/RV64I writeback stage: registers one instruction per cycle, selects
// and formats the writeback value, suppresses x0 writes, counts retirements
// and feeds the forwarding bus straight from its own registers.
module rv_wb_stage #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
) (
  input  logic          clk,
  input  logic          reset,
  rv_wb_stage_if.slave  bus
);

  logic            valid_q,  valid_d;
  logic            wb_en_q,  wb_en_d;
  logic [4:0]      wb_reg_q, wb_reg_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [CNTW-1:0] retire_q, retire_d;

  logic [31:0]     word_s;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;
  logic [XLEN-1:0] load_s;
  logic [XLEN-1:0] src_s;

  assign word_s = bus.mem_rdata[31:0];

  // Pick the addressed byte and halfword lanes out of the low load word
  always_comb begin
    byte_s = word_s[7:0];
    case (bus.ld_addr_lo)
      2'd0:    byte_s = word_s[7:0];
      2'd1:    byte_s = word_s[15:8];
      2'd2:    byte_s = word_s[23:16];
      2'd3:    byte_s = word_s[31:24];
      default: byte_s = word_s[7:0];
    endcase
    if (bus.ld_addr_lo[1]) begin
      half_s = word_s[31:16];
    end else begin
      half_s = word_s[15:0];
    end
  end

  // Size/sign-extend the load lane according to funct3
  always_comb begin
    load_s = bus.mem_rdata;
    case (bus.ld_funct3)
      3'b000:  load_s = XLEN'($signed(byte_s));
      3'b100:  load_s = XLEN'(byte_s);
      3'b001:  load_s = XLEN'($signed(half_s));
      3'b101:  load_s = XLEN'(half_s);
      3'b010:  load_s = XLEN'($signed(word_s));
      3'b110:  load_s = XLEN'(word_s);
      3'b011:  load_s = bus.mem_rdata;
      default: load_s = bus.mem_rdata;
    endcase
  end

  // Writeback source mux; link address wraps modulo 2^XLEN
  always_comb begin
    src_s = bus.alu_in;
    case (bus.src_sel_in)
      2'd0:    src_s = bus.pc_in + XLEN'(3'd4);
      2'd1:    src_s = bus.io_rdata;
      2'd2:    src_s = bus.alu_in;
      2'd3:    src_s = load_s;
      default: src_s = bus.alu_in;
    endcase
  end

  // Next-state: flush inserts a bubble (data/reg hold), stall holds all
  always_comb begin
    valid_d   = valid_q;
    wb_en_d   = wb_en_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    retire_d  = retire_q;
    if (bus.flush_in) begin
      valid_d = 1'b0;
      wb_en_d = 1'b0;
    end else if (bus.stall_in) begin
      valid_d = valid_q;
    end else begin
      valid_d   = bus.valid_in;
      wb_en_d   = bus.valid_in & bus.wb_en_in & (bus.wb_reg_in != 5'd0);
      wb_reg_d  = bus.wb_reg_in;
      wb_data_d = src_s;
      if (bus.valid_in) begin
        retire_d = retire_q + CNTW'(1'b1);
      end else begin
        retire_d = retire_q;
      end
    end
  end

  // Stage registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= 5'd0;
      wb_data_q <= '0;
      retire_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      retire_q  <= retire_d;
    end
  end

  assign bus.valid_out    = valid_q;
  assign bus.wb_en_out    = wb_en_q;
  assign bus.wb_reg_out   = wb_reg_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.retire_count = retire_q;
  assign bus.df_wb_enable = wb_en_q;
  assign bus.df_wb_reg    = wb_reg_q;
  assign bus.df_wb_data   = wb_data_q;

endmodule

// File: tb/tb_rv_wb_stage.sv
// Bench for rv_wb_stage: a 32-bit instance and a 64-bit instance with a
// 4-bit retire counter share stimulus and are checked against a
// transaction-level reference model.
module tb_rv_wb_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_wb_stage_if #(.XLEN(32), .CNTW(32)) bus32 ();
  rv_wb_stage_if #(.XLEN(64), .CNTW(4))  bus64 ();

  rv_wb_stage #(.XLEN(32), .CNTW(32)) dut32 (.clk(clk), .reset(rst), .bus(bus32));
  rv_wb_stage #(.XLEN(64), .CNTW(4))  dut64 (.clk(clk), .reset(rst), .bus(bus64));

  logic        s_stall, s_flush, s_valid, s_en;
  logic [4:0]  s_reg;
  logic [1:0]  s_sel, s_lo;
  logic [2:0]  s_f3;
  logic [63:0] s_pc, s_alu, s_io, s_mem;

  assign bus32.stall_in = s_stall;   assign bus64.stall_in = s_stall;
  assign bus32.flush_in = s_flush;   assign bus64.flush_in = s_flush;
  assign bus32.valid_in = s_valid;   assign bus64.valid_in = s_valid;
  assign bus32.wb_en_in = s_en;      assign bus64.wb_en_in = s_en;
  assign bus32.wb_reg_in = s_reg;    assign bus64.wb_reg_in = s_reg;
  assign bus32.src_sel_in = s_sel;   assign bus64.src_sel_in = s_sel;
  assign bus32.ld_funct3 = s_f3;     assign bus64.ld_funct3 = s_f3;
  assign bus32.ld_addr_lo = s_lo;    assign bus64.ld_addr_lo = s_lo;
  assign bus32.pc_in = s_pc[31:0];   assign bus64.pc_in = s_pc;
  assign bus32.alu_in = s_alu[31:0]; assign bus64.alu_in = s_alu;
  assign bus32.io_rdata = s_io[31:0];   assign bus64.io_rdata = s_io;
  assign bus32.mem_rdata = s_mem[31:0]; assign bus64.mem_rdata = s_mem;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid, m_en;
  logic [4:0]  m_reg;
  logic [63:0] m_d32, m_d64;
  logic [31:0] m_c32;
  logic [3:0]  m_c4;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural writeback value for a given datapath width
  function automatic logic [63:0] ref_wb(input int xlen, input logic [1:0] sel,
      input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] io,
      input logic [63:0] mem, input logic [2:0] f3, input logic [1:0] lo);
    logic [63:0] mask, r, w, b, h;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    w = mem & 64'hFFFF_FFFF;
    b = (w >> (8 * int'(lo))) & 64'hFF;
    h = (w >> (16 * int'(lo[1]))) & 64'hFFFF;
    case (sel)
      2'd0: r = pc + 64'd4;
      2'd1: r = io;
      2'd2: r = alu;
      default: begin
        case (f3)
          3'b000:  r = (b >= 64'd128)   ? b - 64'd256   : b;
          3'b100:  r = b;
          3'b001:  r = (h >= 64'd32768) ? h - 64'd65536 : h;
          3'b101:  r = h;
          3'b010:  r = (w >= 64'h8000_0000) ? w - 64'h1_0000_0000 : w;
          3'b110:  r = w;
          default: r = mem;
        endcase
      end
    endcase
    return r & mask;
  endfunction

  // One clock: snapshot inputs, advance model, compare both instances
  task automatic tick();
    logic [63:0] n32, n64;
    n32 = ref_wb(32, s_sel, s_pc, s_alu, s_io, s_mem, s_f3, s_lo);
    n64 = ref_wb(64, s_sel, s_pc, s_alu, s_io, s_mem, s_f3, s_lo);
    if (rst) begin
      m_valid = 1'b0; m_en = 1'b0; m_reg = 5'd0;
      m_d32 = 64'd0; m_d64 = 64'd0; m_c32 = 32'd0; m_c4 = 4'd0;
    end else if (s_flush) begin
      m_valid = 1'b0; m_en = 1'b0;
    end else if (!s_stall) begin
      m_valid = s_valid;
      m_en    = s_valid && s_en && (s_reg != 5'd0);
      m_reg   = s_reg;
      m_d32   = n32;
      m_d64   = n64;
      if (s_valid) begin
        m_c32 = m_c32 + 32'd1;
        m_c4  = m_c4 + 4'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("valid32",  {63'd0, bus32.valid_out},  {63'd0, m_valid});
    chk("wben32",   {63'd0, bus32.wb_en_out},  {63'd0, m_en});
    chk("wbreg32",  {59'd0, bus32.wb_reg_out}, {59'd0, m_reg});
    chk("wbdata32", {32'd0, bus32.wb_data},    m_d32);
    chk("dfen32",   {63'd0, bus32.df_wb_enable}, {63'd0, m_en});
    chk("dfreg32",  {59'd0, bus32.df_wb_reg},  {59'd0, m_reg});
    chk("dfdata32", {32'd0, bus32.df_wb_data}, m_d32);
    chk("retire32", {32'd0, bus32.retire_count}, {32'd0, m_c32});
    chk("valid64",  {63'd0, bus64.valid_out},  {63'd0, m_valid});
    chk("wben64",   {63'd0, bus64.wb_en_out},  {63'd0, m_en});
    chk("wbdata64", bus64.wb_data,             m_d64);
    chk("dfdata64", bus64.df_wb_data,          m_d64);
    chk("retire4",  {60'd0, bus64.retire_count}, {60'd0, m_c4});
  endtask

  task automatic idle();
    s_stall = 1'b0; s_flush = 1'b0; s_valid = 1'b0; s_en = 1'b0;
    s_reg = 5'd0; s_sel = 2'd0; s_f3 = 3'd0; s_lo = 2'd0;
    s_pc = 64'd0; s_alu = 64'd0; s_io = 64'd0; s_mem = 64'd0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_valid = 1'b0; m_en = 1'b0; m_reg = 5'd0;
    m_d32 = 64'd0; m_d64 = 64'd0; m_c32 = 32'd0; m_c4 = 4'd0;
    @(negedge clk);
    tick();
    chk("reset_cnt", {32'd0, bus32.retire_count}, 64'd0);
    rst = 1'b0;

    // Basic ALU capture
    s_valid = 1'b1; s_en = 1'b1; s_reg = 5'd5; s_sel = 2'd2; s_alu = 64'h1234;
    tick();
    chk("alu_data", {32'd0, bus32.df_wb_data}, 64'h1234);
    chk("alu_cnt",  {32'd0, bus32.retire_count}, 64'd1);

    // Load formatting
    s_sel = 2'd3; s_mem = 64'h80FF_7F01;
    s_f3 = 3'b000; s_lo = 2'd3; tick(); chk("lb3",  {32'd0, bus32.wb_data}, 64'hFFFF_FF80);
    s_f3 = 3'b100; s_lo = 2'd2; tick(); chk("lbu2", {32'd0, bus32.wb_data}, 64'h0000_00FF);
    s_f3 = 3'b001; s_lo = 2'd2; tick(); chk("lh2",  {32'd0, bus32.wb_data}, 64'hFFFF_80FF);
    s_f3 = 3'b101; s_lo = 2'd0; tick(); chk("lhu0", {32'd0, bus32.wb_data}, 64'h0000_7F01);

    // Link address wrap and x0 suppression
    s_sel = 2'd0; s_pc = 64'hFFFF_FFFC; s_reg = 5'd0; s_en = 1'b1;
    tick();
    chk("pc_wrap", {32'd0, bus32.wb_data}, 64'd0);
    chk("x0_en",   {63'd0, bus32.wb_en_out}, 64'd0);

    // Stall then flush sequence
    rst = 1'b1; tick(); rst = 1'b0;
    s_sel = 2'd2; s_reg = 5'd1; s_alu = 64'hA1; tick();
    s_reg = 5'd2; s_alu = 64'hB2; s_stall = 1'b1; tick();
    chk("stall_hold", {32'd0, bus32.wb_data}, 64'hA1);
    s_stall = 1'b0; tick();
    chk("after_stall", {32'd0, bus32.wb_data}, 64'hB2);
    s_reg = 5'd3; s_alu = 64'hC3; s_flush = 1'b1; s_stall = 1'b1; tick();
    chk("flush_data", {32'd0, bus32.wb_data}, 64'hB2);
    chk("flush_cnt",  {32'd0, bus32.retire_count}, 64'd2);
    s_flush = 1'b0; s_stall = 1'b0;

    // 64-bit word loads
    s_sel = 2'd3; s_mem = 64'h8000_0000;
    s_f3 = 3'b010; tick(); chk("lw64",  bus64.wb_data, 64'hFFFF_FFFF_8000_0000);
    s_f3 = 3'b110; tick(); chk("lwu64", bus64.wb_data, 64'h0000_0000_8000_0000);
    s_f3 = 3'b011; s_mem = 64'h0123_4567_89AB_CDEF; tick();
    chk("ld64", bus64.wb_data, 64'h0123_4567_89AB_CDEF);

    // Retire counter wrap on the 4-bit instance
    rst = 1'b1; tick(); rst = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("cnt_max", {60'd0, bus64.retire_count}, 64'd15);
    tick();
    chk("cnt_wrap", {60'd0, bus64.retire_count}, 64'd0);
    rst = 1'b1; s_flush = 1'b1; s_stall = 1'b1; tick();
    chk("rst_all", {32'd0, bus32.wb_data}, 64'd0);
    rst = 1'b0; s_flush = 1'b0; s_stall = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      s_stall = ($urandom_range(0, 5) == 0);
      s_flush = ($urandom_range(0, 7) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_en    = ($urandom_range(0, 3) != 0);
      s_reg   = 5'($urandom_range(0, 31));
      s_sel   = 2'($urandom_range(0, 3));
      s_f3    = 3'($urandom_range(0, 7));
      s_lo    = 2'($urandom_range(0, 3));
      s_pc    = {$urandom(), $urandom()};
      s_alu   = {$urandom(), $urandom()};
      s_io    = {$urandom(), $urandom()};
      s_mem   = {$urandom(), $urandom()};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_wb_stage.md
# rv_wb_stage

Parametrised writeback stage for the RV32I/RV64I pipeline, placed after the memory stage and in front of the register-file write port. It registers one instruction per cycle and selects the writeback source (link address, IO read, ALU result, memory load). It formats load data by width, signedness and byte offset, and drives the hazard unit's forwarding bus from its own registered outputs. Compared with the earlier writeback stage it adds stall/flush control, x0 write suppression and a retired-instruction counter.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- CNTW, 32, retire counter width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- stall_in  in  1  hold all stage registers
- flush_in  in  1  kill the instruction being captured
- valid_in  in  1  upstream instruction valid
- wb_en_in  in  1  instruction writes a register
- wb_reg_in  in  5  destination register
- src_sel_in  in  2  0 = pc_in+4, 1 = io_rdata, 2 = alu_in, 3 = formatted mem_rdata
- pc_in, alu_in, io_rdata, mem_rdata  in  XLEN  source operands
- ld_funct3  in  3  load funct3
- ld_addr_lo  in  2  load address bits [1:0]
- valid_out  out  1  stage holds a valid instruction
- wb_en_out  out  1  register-file write enable
- wb_reg_out  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- df_wb_enable, df_wb_reg, df_wb_data  out  1/5/XLEN  forwarding bus
- retire_count  out  CNTW  count of retired instructions

## Operation
- Priority on each clk edge: reset > flush_in > stall_in > capture.
- reset: valid_out, wb_en_out, wb_reg_out, wb_data and retire_count all clear to 0.
- flush_in:
  - valid_out and wb_en_out go to 0.
  - wb_reg_out and wb_data hold.
  - retire_count does not change.
- stall_in (flush_in low): every register holds.
- Capture:
  - valid_out <= valid_in.
  - wb_en_out <= valid_in & wb_en_in & (wb_reg_in != 0). Writes to x0 are always suppressed.
  - wb_reg_out <= wb_reg_in.
  - wb_data <= selected source.
  - retire_count increments by 1 when valid_in = 1. It wraps modulo 2^CNTW.
- Source 0: pc_in + 4, computed modulo 2^XLEN.
- Load formatting applies only to source 3. Byte lanes come from mem_rdata[31:0].
  - funct3 000 (LB): byte selected by ld_addr_lo, sign-extended.
  - funct3 100 (LBU): byte selected by ld_addr_lo, zero-extended.
  - funct3 001 (LH) and 101 (LHU): halfword selected by ld_addr_lo[1]; bit 0 is ignored. LH sign-extends, LHU zero-extends.
  - funct3 010 (LW): low word, sign-extended to XLEN. Identity when XLEN = 32.
  - funct3 110 (LWU): low word, zero-extended.
  - funct3 011 (LD): full mem_rdata. Only meaningful when XLEN = 64.
  - funct3 111: full mem_rdata.
- Forwarding outputs are direct copies of the stage registers: df_wb_enable = wb_en_out, df_wb_reg = wb_reg_out, df_wb_data = wb_data.

## Timing
- Latency: 1 cycle from input to wb_* outputs. Throughput: 1 instruction per cycle when not stalled.
- Forwarding bus is valid in the same cycle as the wb_* outputs. It carries no combinational path from the inputs.
- Flush and stall asserted together: flush wins, and the bubble is inserted.
- Reset asserted mid-stall or mid-flush: all outputs read 0 on the next cycle.
- retire_count at 2^CNTW-1 with a valid capture wraps to 0 on that edge.

## Test plan
- Reset, then capture valid_in=1, wb_en_in=1, wb_reg_in=5, src_sel=2, alu_in=0x1234 -> next cycle: wb_en_out=1, wb_reg_out=5, wb_data=0x1234, df_wb_data=0x1234, retire_count=1.
- Load formatting, src_sel=3, mem_rdata=0x80FF7F01:
  - LB at offset 3 -> 0xFFFFFF80.
  - LBU at offset 2 -> 0x000000FF.
  - LH at offset 2 -> 0xFFFF80FF.
  - LHU at offset 0 -> 0x00007F01.
- src_sel=0, pc_in=0xFFFFFFFC -> wb_data=0x00000000. With wb_reg_in=0 and wb_en_in=1 -> wb_en_out=0, valid_out=1, retire_count still increments.
- Sequence A, B, C with stall_in held high on B's capture edge -> outputs hold A for 2 cycles, then show B. With flush_in high on C's capture edge -> valid_out=0, wb_en_out=0, wb_data still B. retire_count ends at 2.
- Preload retire_count to 0xFFFFFFFF via valid captures; next valid capture -> retire_count=0. Then assert reset together with flush_in and stall_in -> all outputs 0.
- XLEN=64: LW of 0x80000000 -> 0xFFFFFFFF80000000. LWU -> 0x0000000080000000. LD -> full 64-bit value.
